// File: rtl/fetch_pkg.sv
// Types shared by the fetch stage and its skid buffer.
`ifndef FETCH_CONSTANTS_SV
`include "constants.sv"
`endif

package fetch_pkg;

    typedef enum logic [`FETCH_ST_WIDTH-1:0] {
        ST_IDLE = `FETCH_ST_IDLE,
        ST_WAIT = `FETCH_ST_WAIT,
        ST_DROP = `FETCH_ST_DROP
    } fetch_st_e;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [15:0] align_pc(input logic [15:0] pc);
        return pc & 16'hFFFC;
    endfunction

endpackage

// File: rtl/constants.sv
// Shared encodings for the fetch stage request FSM and the canonical NOP word.
`ifndef FETCH_CONSTANTS_SV
`define FETCH_CONSTANTS_SV
`define FETCH_ST_WIDTH 2
`define FETCH_ST_IDLE 2'd0
`define FETCH_ST_WAIT 2'd1
`define FETCH_ST_DROP 2'd2
`define INST_NOP 32'h00000013
`endif

// File: rtl/fetch_skid_buf.sv
// One-entry {pc,inst} holding buffer; registered, no added latency on push.
// Push overrides a same-cycle pop; flush overrides both.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    input  logic         flush,
    output logic         skid_vld,
    output fetch_entry_t skid_dat
);

    logic         vld_q, vld_d;
    fetch_entry_t dat_q, dat_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (push_vld) begin
            vld_d = 1'b1;
            dat_d = push_dat;
        end else if (pop) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign skid_vld = vld_q;
    assign skid_dat = dat_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, 2-cycle accept-to-decode latency.
// Decode stall holds the output regs; a 1-entry skid absorbs the in-flight response.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        decode_stall,
    output logic        decode_valid,
    output logic [15:0] decode_pc,
    output logic [31:0] decode_inst
);

    fetch_st_e    state_q, state_d;
    logic [15:0]  fetch_pc_q, fetch_pc_d;
    logic [15:0]  req_pc_q, req_pc_d;
    logic         out_vld_q, out_vld_d;
    fetch_entry_t out_q, out_d;

    logic         skid_vld;
    fetch_entry_t skid_dat;
    logic         consume, accept, resp, load_out, skid_push, skid_pop;
    logic [1:0]   occ;
    fetch_entry_t resp_entry;

    always_comb begin
        consume    = out_vld_q && !decode_stall;
        occ        = 2'(out_vld_q && decode_stall) + 2'(skid_vld) + 2'(state_q == ST_WAIT);
        imem_req   = !rst && !redirect_valid && (state_q != ST_DROP)
                     && (state_q == ST_IDLE || imem_rvalid) && (occ <= 2'd1);
        accept     = imem_req && imem_ready;
        resp       = (state_q == ST_WAIT) && imem_rvalid && !redirect_valid;
        load_out   = resp && (!out_vld_q || consume) && !skid_vld;
        skid_push  = resp && !load_out;
        skid_pop   = consume && skid_vld;
        resp_entry = '{pc: req_pc_q, inst: imem_rdata};
    end

    // A response landing in the redirect cycle is simply not loaded; only a
    // response still in flight after the redirect needs the DROP state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_WAIT;
            ST_WAIT: begin
                if (imem_rvalid)         state_d = accept ? ST_WAIT : ST_IDLE;
                else if (redirect_valid) state_d = ST_DROP;
            end
            ST_DROP: if (imem_rvalid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + 16'd4;
            req_pc_d   = fetch_pc_q;
        end
    end

    always_comb begin
        out_vld_d = out_vld_q;
        out_d     = out_q;
        if (redirect_valid) begin
            out_vld_d = 1'b0;
        end else if (skid_pop) begin
            out_vld_d = 1'b1;
            out_d     = skid_dat;
        end else if (load_out) begin
            out_vld_d = 1'b1;
            out_d     = resp_entry;
        end else if (consume) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            out_vld_q  <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            out_vld_q  <= out_vld_d;
            out_q      <= out_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .push_vld (skid_push),
        .push_dat (resp_entry),
        .pop      (skid_pop),
        .flush    (redirect_valid),
        .skid_vld (skid_vld),
        .skid_dat (skid_dat)
    );

    assign imem_addr   = fetch_pc_q;
    assign decode_valid = out_vld_q;
    assign decode_pc    = out_q.pc;
    assign decode_inst  = out_q.inst;

    a_skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(skid_push && skid_vld && !skid_pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural instruction memory of configurable latency.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        decode_stall;
    logic        decode_valid;
    logic [15:0] decode_pc;
    logic [31:0] decode_inst;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .decode_stall   (decode_stall),
        .decode_valid   (decode_valid),
        .decode_pc      (decode_pc),
        .decode_inst    (decode_inst)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mem_lat = 1;
    int          pend_cnt = 0;
    logic        pend_vld = 1'b0;
    logic [15:0] pend_addr = 16'h0000;

    function automatic logic [31:0] inst_of(input logic [15:0] a);
        return {16'h1357, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; the memory model records a handshake seen before the edge.
    task automatic tick();
        logic        acc;
        logic [15:0] a;
        @(negedge clk);
        acc = imem_req && imem_ready;
        a   = imem_addr;
        @(posedge clk);
        #1;
        if (rst) begin
            pend_vld = 1'b0;
        end else begin
            if (pend_vld) begin
                if (imem_rvalid) pend_vld = 1'b0;
                else             pend_cnt--;
            end
            if (acc) begin
                pend_vld  = 1'b1;
                pend_addr = a;
                pend_cnt  = mem_lat;
            end
        end
        imem_rvalid = pend_vld && (pend_cnt == 1);
        imem_rdata  = imem_rvalid ? inst_of(pend_addr) : 32'hDEADBEEF;
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        decode_stall   = 1'b0;
        imem_ready     = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        decode_stall   = 1'b0;
        imem_ready     = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_dvalid", 32'(decode_valid), 32'd0);
        check("rst_dpc",    32'(decode_pc),    32'd0);
        check("rst_dinst",  decode_inst,       32'd0);
        check("rst_req",    32'(imem_req),     32'd0);

        // Streaming with 1-cycle memory, then a 3-cycle stall at pc 8
        mem_lat = 1;
        rst = 1'b0;
        #1;
        check("s_c0_req",  32'(imem_req),  32'd1);
        check("s_c0_addr", 32'(imem_addr), 32'h0000);
        tick();
        check("s_c1_addr",   32'(imem_addr),    32'h0004);
        check("s_c1_dvalid", 32'(decode_valid), 32'd0);
        tick();
        check("s_c2_dvalid", 32'(decode_valid), 32'd1);
        check("s_c2_dpc",    32'(decode_pc),    32'h0000);
        check("s_c2_dinst",  decode_inst,       inst_of(16'h0000));
        check("s_c2_addr",   32'(imem_addr),    32'h0008);
        tick();
        check("s_c3_dpc", 32'(decode_pc), 32'h0004);
        tick();
        check("s_c4_dpc", 32'(decode_pc), 32'h0008);
        decode_stall = 1'b1;
        #1;
        check("st_c4_req", 32'(imem_req), 32'd0);
        for (int i = 5; i <= 6; i++) begin
            tick();
            check("st_hold_dpc",   32'(decode_pc),    32'h0008);
            check("st_hold_dinst", decode_inst,       inst_of(16'h0008));
            check("st_hold_req",   32'(imem_req),     32'd0);
        end
        tick();
        decode_stall = 1'b0;
        #1;
        check("st_c7_dpc",  32'(decode_pc), 32'h0008);
        check("st_c7_req",  32'(imem_req),  32'd1);
        check("st_c7_addr", 32'(imem_addr), 32'h0010);
        tick();
        check("st_c8_dpc",   32'(decode_pc),    32'h000C);
        check("st_c8_dinst", decode_inst,       inst_of(16'h000C));
        tick();
        check("st_c9_dpc",    32'(decode_pc),    32'h0010);
        check("st_c9_dvalid", 32'(decode_valid), 32'd1);

        // Redirect while a 2-cycle response is in flight
        mem_lat = 2;
        do_reset();
        tick();
        check("rw_c1_req", 32'(imem_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0102;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rw_c2_dvalid", 32'(decode_valid), 32'd0);
        check("rw_c2_req",    32'(imem_req),     32'd0);
        tick();
        check("rw_c3_dvalid", 32'(decode_valid), 32'd0);
        check("rw_c3_req",    32'(imem_req),     32'd1);
        check("rw_c3_addr",   32'(imem_addr),    32'h0100);
        tick();
        tick();
        tick();
        check("rw_c6_dvalid", 32'(decode_valid), 32'd1);
        check("rw_c6_dpc",    32'(decode_pc),    32'h0100);
        check("rw_c6_dinst",  decode_inst,       inst_of(16'h0100));

        // Redirect coinciding with a response under stall, then with a full skid
        mem_lat = 1;
        do_reset();
        tick();
        tick();
        decode_stall   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        #1;
        check("rr_c2_req", 32'(imem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rr_c3_dvalid", 32'(decode_valid), 32'd0);
        check("rr_c3_req",    32'(imem_req),     32'd1);
        check("rr_c3_addr",   32'(imem_addr),    32'h0200);
        tick();
        tick();
        check("rr_c5_dvalid", 32'(decode_valid), 32'd1);
        check("rr_c5_dpc",    32'(decode_pc),    32'h0200);
        tick();
        check("rr_c6_dpc", 32'(decode_pc), 32'h0200);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0300;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rs_c7_dvalid", 32'(decode_valid), 32'd0);
        check("rs_c7_addr",   32'(imem_addr),    32'h0300);
        check("rs_c7_req",    32'(imem_req),     32'd1);
        tick();
        tick();
        check("rs_c9_dvalid", 32'(decode_valid), 32'd1);
        check("rs_c9_dpc",    32'(decode_pc),    32'h0300);
        decode_stall = 1'b0;
        tick();
        check("rs_c10_dpc", 32'(decode_pc), 32'h0304);

        // PC wrap, reached via an unaligned redirect target
        mem_lat = 1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        #1;
        check("wr_c0_req", 32'(imem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("wr_c1_addr", 32'(imem_addr), 32'hFFFC);
        check("wr_c1_req",  32'(imem_req),  32'd1);
        tick();
        check("wr_c2_addr", 32'(imem_addr), 32'h0000);
        tick();
        check("wr_c3_dpc", 32'(decode_pc), 32'hFFFC);
        tick();
        check("wr_c4_dpc",   32'(decode_pc), 32'h0000);
        check("wr_c4_dinst", decode_inst,    inst_of(16'h0000));

        // Memory not ready for 4 cycles, then reset while waiting
        mem_lat = 8;
        do_reset();
        imem_ready = 1'b0;
        #1;
        check("nr_c0_req",  32'(imem_req),  32'd1);
        check("nr_c0_addr", 32'(imem_addr), 32'h0000);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("nr_hold_req",  32'(imem_req),  32'd1);
            check("nr_hold_addr", 32'(imem_addr), 32'h0000);
        end
        tick();
        imem_ready = 1'b1;
        #1;
        check("nr_c4_req", 32'(imem_req), 32'd1);
        tick();
        check("nr_c5_req", 32'(imem_req), 32'd0);
        rst = 1'b1;
        #1;
        check("nr_rst_req", 32'(imem_req), 32'd0);
        tick();
        check("nr_rst_dvalid", 32'(decode_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("nr_post_req",  32'(imem_req),  32'd1);
        check("nr_post_addr", 32'(imem_addr), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
